// File: rtl/display_scan_pkg.sv
// Shared state encoding, code width and width helpers for the display scan controller.
package display_scan_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Digit-bank update handshake between host logic (master) and the scan controller (slave).
interface display_scan_controller_if
    import display_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    logic                         upd_req;
    logic [CODE_W*NUM_DIGITS-1:0] upd_data;
    logic                         upd_ack;

    modport master (output upd_req, output upd_data, input upd_ack);
    modport slave  (input upd_req, input upd_data, output upd_ack);

endinterface

// File: rtl/display_scan_controller_phase_counter.sv
// Loadable down-counter that holds at zero; tc flags the last cycle of a scan phase.
module scan_phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state only ever takes non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexes one segment decoder across NUM_DIGITS positions with blanking and a double-buffered bank.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module display_scan_controller
    import display_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    display_scan_controller_if.slave upd,
    output logic [CODE_W-1:0]        decoder_code,
    output logic [NUM_DIGITS-1:0]    digit_enable,
    output logic                     frame_start
);

    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int CNT_W = clog2(max3(DIGIT_CYCLES, BLANK_CYCLES, 2));
    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] bank_t;

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    bank_t                 active_q, active_d;
    bank_t                 pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic                  upd_ack_q, upd_ack_d;
    logic [CODE_W-1:0]     decoder_code_q, decoder_code_d;
    logic [NUM_DIGITS-1:0] digit_enable_q, digit_enable_d;
    logic                  frame_start_q, frame_start_d;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_value;
    logic                  cnt_tc;
    logic                  swap;

    scan_phase_counter #(.WIDTH(CNT_W)) u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .tc         (cnt_tc)
    );

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        upd_ack_d       = 1'b0;
        frame_start_d   = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_value  = DIGIT_LOAD;
        swap            = pending_valid_q && (state_q == IDLE);

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d         = '0;
                    frame_start_d = 1'b1;
                    cnt_load      = 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_d        = BLANK;
                        cnt_load_value = BLANK_LOAD;
                    end else begin
                        state_d = SHOW;
                    end
                end
                BLANK: begin
                    if (cnt_tc) begin
                        state_d  = SHOW;
                        cnt_load = 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d         = '0;
                            frame_start_d = 1'b1;
                            swap          = pending_valid_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                        if (BLANK_CYCLES > 0) begin
                            state_d        = BLANK;
                            cnt_load_value = BLANK_LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A swap and a capture are exclusive: swap needs pending_valid, capture needs it clear.
        if (swap) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (upd.upd_req && !pending_valid_q) begin
            pending_d       = upd.upd_data;
            pending_valid_d = 1'b1;
            upd_ack_d       = 1'b1;
        end
    end

    // Outputs are derived from next-state values so the registered outputs track the state.
    always_comb begin
        decoder_code_d = '0;
        digit_enable_d = '0;
        if (state_d != IDLE) begin
            decoder_code_d = active_d[idx_d];
        end
        if (state_d == SHOW) begin
            digit_enable_d = NUM_DIGITS'(1) << idx_d;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d != '0 && (active_d >> (CODE_W * int'(idx_d))) == '0) begin
            digit_enable_d = '0;
        end
`else
`endif
    end

    // NOTE: the digit banks are reset as well so a restart never shows stale codes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            upd_ack_q       <= 1'b0;
            decoder_code_q  <= '0;
            digit_enable_q  <= '0;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            upd_ack_q       <= upd_ack_d;
            decoder_code_q  <= decoder_code_d;
            digit_enable_q  <= digit_enable_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign upd.upd_ack   = upd_ack_q;
    assign decoder_code  = decoder_code_q;
    assign digit_enable  = digit_enable_q;
    assign frame_start   = frame_start_q;

endmodule
